slc3_mem_seq: RTL and testbench

//  Parametrised memory/I-O access sequencer that sits between the SLC-3 control

---
 rtl/slc3_mem_seq.sv | 130 +++++++++++++
 tb/tb_slc3_mem_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_seq.sv
// rtl/slc3_mem_seq.sv - SLC-3 memory/I-O access sequencer with req/ack handshake and SRAM wait states
module slc3_mem_seq #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = '1,
    parameter int                HEX_DIGITS  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ack,
    output logic                    busy,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [DATA_W-1:0]       sram_wdata,
    input  logic [DATA_W-1:0]       sram_rdata,
    output logic                    sram_oe,
    output logic                    sram_we,
    input  logic [DATA_W-1:0]       switches,
    output logic [4*HEX_DIGITS-1:0] hex_out
);

    localparam int         HEX_W = 4 * HEX_DIGITS;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic [HEX_W-1:0]    hex_nxt;
    logic                oe_nxt, we_nxt, ack_nxt;

    // Strobes and ack are computed for the next state so they come straight off flops.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = sram_addr;
        wdata_nxt = sram_wdata;
        rdata_nxt = rdata;
        hex_nxt   = hex_out;
        oe_nxt    = 1'b0;
        we_nxt    = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    addr_nxt  = addr;
                    wdata_nxt = wdata;
                    cnt_nxt   = 4'd0;
                    if (addr == IO_ADDR) begin
                        state_nxt = DONE;
                        ack_nxt   = 1'b1;
                        if (we)
                            hex_nxt = wdata[HEX_W-1:0];
                        else
                            rdata_nxt = switches;
                    end else if (we) begin
                        state_nxt = WR;
                        we_nxt    = 1'b1;
                    end else begin
                        state_nxt = RD;
                        oe_nxt    = 1'b1;
                    end
                end
            end
            RD: begin
                if (cnt == WS) begin
                    rdata_nxt = sram_rdata;
                    state_nxt = DONE;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                    oe_nxt  = 1'b1;
                end
            end
            WR: begin
                if (cnt == WS) begin
                    state_nxt = WR_HOLD;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                    we_nxt  = 1'b1;
                end
            end
            WR_HOLD: begin
                state_nxt = DONE;
                ack_nxt   = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata      <= '0;
            hex_out    <= '0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            ack        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            rdata      <= rdata_nxt;
            hex_out    <= hex_nxt;
            sram_oe    <= oe_nxt;
            sram_we    <= we_nxt;
            ack        <= ack_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_slc3_mem_seq.sv
// tb/tb_slc3_mem_seq.sv - directed table-driven bench for slc3_mem_seq (WAIT_STATES=2 and 0)
module tb_slc3_mem_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req, we;
    logic [15:0] addr, wdata, rdata, sram_addr, sram_wdata, sram_rdata, switches, hex_out;
    logic        ack, busy, sram_oe, sram_we;

    logic        z_req, z_we;
    logic [15:0] z_addr, z_wdata, z_rdata, z_sram_addr, z_sram_wdata, z_sram_rdata, z_switches, z_hex_out;
    logic        z_ack, z_busy, z_sram_oe, z_sram_we;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    slc3_mem_seq #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(2), .IO_ADDR(16'hFFFF), .HEX_DIGITS(4)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_oe(sram_oe), .sram_we(sram_we),
        .switches(switches), .hex_out(hex_out)
    );

    slc3_mem_seq #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(0), .IO_ADDR(16'hFFFF), .HEX_DIGITS(4)) dut0 (
        .Clk(Clk), .Reset(Reset), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
        .rdata(z_rdata), .ack(z_ack), .busy(z_busy), .sram_addr(z_sram_addr), .sram_wdata(z_sram_wdata),
        .sram_rdata(z_sram_rdata), .sram_oe(z_sram_oe), .sram_we(z_sram_we),
        .switches(z_switches), .hex_out(z_hex_out)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] srd;
        logic [15:0] sw;
        logic [15:0] exp_rdata;
        logic [15:0] exp_hex;
        int          lat;
        int          oe_n;
        int          we_n;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        int lat, oe_n, we_n, both, bad;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge Clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        sram_rdata = v.srd; switches = v.sw;
        @(posedge Clk);
        #1;
        req = 1'b0; we = ~v.we; addr = ~v.addr; wdata = ~v.wdata;
        lat = 0; oe_n = 0; we_n = 0; both = 0; bad = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge Clk);
            if (sram_oe) oe_n++;
            if (sram_we) we_n++;
            if (sram_oe && sram_we) both++;
            if (busy && (sram_addr !== v.addr || (v.we && sram_wdata !== v.wdata))) bad++;
            if (ack) lat = c;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_oe_cycles"}, 32'(oe_n), 32'(v.oe_n));
        check({tag, "_we_cycles"}, 32'(we_n), 32'(v.we_n));
        check({tag, "_both_strobes"}, 32'(both), 32'd0);
        check({tag, "_addr_data_stable"}, 32'(bad), 32'd0);
        check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, v.exp_rdata});
        check({tag, "_hex"}, {16'd0, hex_out}, {16'd0, v.exp_hex});
    endtask

    initial begin
        int acks;
        int ack_cyc[3];
        vec_t post;

        vecs[0] = '{1'b0, 16'h0030, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 4, 3, 0};
        vecs[1] = '{1'b1, 16'h0031, 16'h1234, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 5, 0, 3};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hA5C3, 16'h0000, 16'h0000, 16'hBEEF, 16'hA5C3, 1, 0, 0};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h9999, 16'h00F7, 16'h00F7, 16'hA5C3, 1, 0, 0};
        vecs[4] = '{1'b0, 16'h1234, 16'h0000, 16'h5A5A, 16'hFFFF, 16'h5A5A, 16'hA5C3, 4, 3, 0};
        vecs[5] = '{1'b1, 16'h0040, 16'hFFFF, 16'h0000, 16'h0000, 16'h5A5A, 16'hA5C3, 5, 0, 3};
        vecs[6] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h5A5A, 16'h0001, 1, 0, 0};

        Reset = 1'b0; req = 1'b1; we = 1'b0; addr = 16'h0030; wdata = 16'h1111;
        sram_rdata = 16'hBEEF; switches = 16'h00F7;
        z_req = 1'b1; z_we = 1'b0; z_addr = 16'h0100; z_wdata = 16'h0; z_sram_rdata = 16'h0; z_switches = 16'h0;

        // Reset held for two edges with req asserted
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("rst%0d_ctl", i), {28'd0, ack, busy, sram_oe, sram_we}, 32'd0);
            check($sformatf("rst%0d_rdata", i), {16'd0, rdata}, 32'd0);
            check($sformatf("rst%0d_hex", i), {16'd0, hex_out}, 32'd0);
            check($sformatf("rst%0d_sram", i), {sram_addr, sram_wdata}, 32'd0);
        end
        req = 1'b0; z_req = 1'b0;
        Reset = 1'b1;

        for (int i = 0; i < 7; i++)
            do_vec(vecs[i], i);

        // Reset during the second RD cycle aborts the access
        @(negedge Clk);
        req = 1'b1; we = 1'b0; addr = 16'h0050; sram_rdata = 16'h1111;
        @(posedge Clk);
        #1 req = 1'b0;
        @(negedge Clk);
        check("abort_oe_rd1", {31'd0, sram_oe}, 32'd1);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("abort_ctl", {28'd0, ack, busy, sram_oe, sram_we}, 32'd0);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        Reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (ack) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);

        post = '{1'b0, 16'h0060, 16'h0000, 16'h7777, 16'h0000, 16'h7777, 16'h0000, 4, 3, 0};
        do_vec(post, 7);

        // WAIT_STATES=0 instance: req held high for three back-to-back reads
        @(negedge Clk);
        z_req = 1'b1; z_we = 1'b0; z_addr = 16'h0100; z_sram_rdata = 16'hC000;
        acks = 0;
        for (int c = 1; c <= 20 && acks < 3; c++) begin
            @(negedge Clk);
            if (z_ack) begin
                ack_cyc[acks] = c;
                check($sformatf("ws0_rdata%0d", acks), {16'd0, z_rdata}, {16'd0, 16'hC000 + 16'(acks)});
                check($sformatf("ws0_addr%0d", acks), {16'd0, z_sram_addr}, {16'd0, 16'h0100 + 16'(acks)});
                acks++;
            end
            if (z_busy) begin
                z_addr = 16'hDEAD; z_we = 1'b1; z_wdata = 16'hBAD0;
            end else begin
                z_addr = 16'h0100 + 16'(acks); z_we = 1'b0; z_sram_rdata = 16'hC000 + 16'(acks);
            end
        end
        z_req = 1'b0;
        check("ws0_ack_count", 32'(acks), 32'd3);
        if (acks == 3) begin
            check("ws0_first_ack", 32'(ack_cyc[0]), 32'd2);
            check("ws0_spacing1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
            check("ws0_spacing2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
        end
        check("ws0_hex_untouched", {16'd0, z_hex_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
